iter_shifter: RTL and testbench

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/iter_shifter.sv | 134 +++++++++++++
 tb/tb_iter_shifter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Iterative 8-bit shifter/rotator. A request is accepted in IDLE; the work
// register is then moved one bit per cycle in SHIFT until the latched count
// is exhausted. The result is presented in DONE until the consumer takes it.
module iter_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic [2:0] n,
    input  logic       lr,
    input  logic       rot,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [7:0] work_r;
    logic [2:0] count_r;
    logic       lr_r;
    logic       rot_r;
    logic [7:0] step_s;
    logic [7:0] out_r;
    logic       out_valid_r;

    // One-bit move of v: left or right, vacated bit gets zero or the wrapped bit.
    function automatic logic [7:0] step1(input logic [7:0] v,
                                         input logic       left,
                                         input logic       rotate);
        logic fill;
        if (left) begin
            fill  = rotate ? v[7] : 1'b0;
            step1 = {v[6:0], fill};
        end else begin
            fill  = rotate ? v[0] : 1'b0;
            step1 = {fill, v[7:1]};
        end
    endfunction

    // Next value of the work register for the current SHIFT cycle.
    always_comb begin
        step_s = step1(work_r, lr_r, rot_r);
    end

    // Next-state decode of the three-state controller.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = (n == 3'd0) ? DONE : SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (count_r == 3'd1) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, operand latches, work register and result register; rst wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            work_r      <= 8'h00;
            count_r     <= 3'd0;
            lr_r        <= 1'b0;
            rot_r       <= 1'b0;
            out_r       <= 8'h00;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r  <= in;
                        count_r <= n;
                        lr_r    <= lr;
                        rot_r   <= rot;
                        if (n == 3'd0) begin
                            out_r       <= in;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_r  <= step_s;
                    count_r <= count_r - 3'd1;
                    if (count_r == 3'd1) begin
                        out_r       <= step_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = (state_r != IDLE);
    // Qualified by rst so no request looks acceptable while reset is applied.
    assign in_ready  = (state_r == IDLE) && !rst;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: table of single operations plus
// hand-written sequences for back-pressure, input interference and reset abort.
module tb_iter_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_d = 8'h00;
    logic [2:0] n_d = 3'd0;
    logic       lr_d = 1'b0;
    logic       rot_d = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_q;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int accepts = 0;

    iter_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_d),
        .n         (n_d),
        .lr        (lr_d),
        .rot       (rot_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) accepts <= accepts + 1;
    end

    typedef struct {
        logic [7:0] a;
        logic [2:0] sh;
        logic       l;
        logic       r;
        logic [7:0] exp_v;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete request with out_ready = 1; called and returns at a negedge.
    task automatic do_op(input logic [7:0] a, input logic [2:0] sh, input logic l,
                         input logic r, input logic [7:0] exp_v, input string nm);
        int lat;
        check({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_d = a; n_d = sh; lr_d = l; rot_d = r; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_d = ~a; n_d = sh + 3'd1; lr_d = ~l; rot_d = ~r;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, " latency"}, lat, {29'd0, sh});
        check({nm, " out"}, {24'd0, out_q}, {24'd0, exp_v});
        tick();
        check({nm, " idle out_valid"}, {31'd0, out_valid}, 32'd0);
        check({nm, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        int a0;
        int lat;
        vecs[0] = '{8'b10110100, 3'd3, 1'b1, 1'b0, 8'b10100000};
        vecs[1] = '{8'b10110100, 3'd1, 1'b0, 1'b0, 8'b01011010};
        vecs[2] = '{8'b10110100, 3'd4, 1'b0, 1'b0, 8'b00001011};
        vecs[3] = '{8'b10110100, 3'd2, 1'b1, 1'b1, 8'b11010010};
        vecs[4] = '{8'b10110100, 3'd7, 1'b0, 1'b1, 8'b01101001};
        vecs[5] = '{8'h01,       3'd7, 1'b1, 1'b0, 8'h80};
        vecs[6] = '{8'h01,       3'd1, 1'b0, 1'b1, 8'h80};

        // Reset state
        @(negedge clk);
        check("in_ready during rst", {31'd0, in_ready}, 32'd0);
        tick();
        check("rst out", {24'd0, out_q}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Table-driven single operations, back to back
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].sh, vecs[i].l, vecs[i].r, vecs[i].exp_v,
                  $sformatf("vec%0d", i));
        end

        // Zero shift with back-pressure
        out_ready = 1'b0;
        in_d = 8'hA5; n_d = 3'd0; lr_d = 1'b1; rot_d = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_d = 8'h00;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp out_valid %0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp out %0d", k), {24'd0, out_q}, 32'hA5);
            check($sformatf("bp in_ready %0d", k), {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp out held", {24'd0, out_q}, 32'hA5);

        // Input interference during SHIFT of an n = 5 rotate left
        a0 = accepts;
        in_d = 8'b10110100; n_d = 3'd5; lr_d = 1'b1; rot_d = 1'b1; in_valid = 1'b1;
        tick();
        in_d = 8'hFF; n_d = 3'd2; lr_d = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("intf busy", {31'd0, busy}, 32'd1);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("intf latency", lat, 32'd5);
        check("intf out", {24'd0, out_q}, 32'b10010110);
        tick();
        check("intf accepts", accepts - a0, 32'd1);

        // Reset at the second SHIFT cycle of an n = 6 op
        in_d = 8'h3C; n_d = 3'd6; lr_d = 1'b1; rot_d = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort out", {24'd0, out_q}, 32'd0);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                check("abort no result", {31'd0, out_valid}, 32'd0);
            end
            tick();
        end
        check("abort still idle", {31'd0, busy}, 32'd0);
        do_op(8'b10110100, 3'd6, 1'b1, 1'b0, 8'b00000000, "after abort lsl");
        do_op(8'h96, 3'd5, 1'b0, 1'b1, 8'hB4, "after abort ror");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
